// File: rtl/round_key_gen_if.sv
// Handshake and key bus between the AES-128 key-schedule engine and the round controller.
// The controller side is the master; the key engine is the slave.
interface round_key_gen_if;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  key_valid, round_key, round_num, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output key_valid, round_key, round_num, busy, done
  );
endinterface

// File: rtl/round_key_gen.sv
// Sequential AES-128 key schedule: captures the cipher key on start and hands out
// round keys 0..10, one per accepted handshake, expanding one round per cycle.
module round_key_gen (
  input  logic            clk,
  input  logic            n_rst,
  round_key_gen_if.slave  bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       state_q, state_d;
  logic [127:0] roundKey_q, roundKey_d;
  logic [3:0]   roundNum_q, roundNum_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rotWord, subWord, tWord;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] nextKey;

  assign {w0, w1, w2, w3} = roundKey_q;
  assign rotWord = {w3[23:0], w3[31:24]};
  assign subWord = {sbox(rotWord[31:24]), sbox(rotWord[23:16]),
                    sbox(rotWord[15:8]),  sbox(rotWord[7:0])};
  assign tWord   = subWord ^ {rcon_q, 24'h000000};
  assign n0      = w0 ^ tWord;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign nextKey = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      roundKey_q <= '0;
      roundNum_q <= '0;
      rcon_q     <= 8'h01;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      roundKey_q <= roundKey_d;
      roundNum_q <= roundNum_d;
      rcon_q     <= rcon_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    roundKey_d = roundKey_q;
    roundNum_d = roundNum_q;
    rcon_d     = rcon_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          roundKey_d = bus.key_in;
          roundNum_d = 4'd0;
          rcon_d     = 8'h01;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        // The last key keeps its value after acceptance so it stays observable.
        if (bus.key_ready) begin
          if (roundNum_q == 4'd10) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            roundKey_d = nextKey;
            roundNum_d = roundNum_q + 4'd1;
            rcon_d     = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.key_valid = (state_q == EMIT);
  assign bus.busy      = (state_q == EMIT);
  assign bus.round_key = roundKey_q;
  assign bus.round_num = roundNum_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_round_key_gen.sv
// Directed bench for round_key_gen using FIPS-197 key-expansion vectors.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_round_key_gen;

  logic clk;
  logic nRst;
  int   vectors;
  int   miscompares;

  logic [127:0] fipsKey;
  logic [127:0] key2;
  logic [127:0] otherKey;
  logic [127:0] expFips [0:10];
  logic [127:0] key2R1;
  logic [127:0] key2R10;

  round_key_gen_if bus ();

  round_key_gen dut (
    .clk   (clk),
    .n_rst (nRst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic startV, input logic [127:0] keyV, input logic readyV);
    bus.start     = startV;
    bus.key_in    = keyV;
    bus.key_ready = readyV;
  endtask

  // Full output compare: {key_valid, busy, done, round_num, round_key}.
  task automatic checkOutput(input string tag, input logic expValid, input logic expBusy,
                             input logic expDone, input logic [3:0] expNum,
                             input logic [127:0] expKey);
    logic [134:0] observed;
    logic [134:0] expected;
    observed = {bus.key_valid, bus.busy, bus.done, bus.round_num, bus.round_key};
    expected = {expValid, expBusy, expDone, expNum, expKey};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s miscompared", tag);
    end
  endtask

  // Status-only compare for rounds whose key value is not tabulated.
  task automatic checkNum(input string tag, input logic [3:0] expNum);
    logic [6:0] observed;
    logic [6:0] expected;
    observed = {bus.key_valid, bus.busy, bus.done, bus.round_num};
    expected = {1'b1, 1'b1, 1'b0, expNum};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s miscompared", tag);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fipsKey     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key2        = 128'h000102030405060708090a0b0c0d0e0f;
    otherKey    = 128'hdeadbeef0123456789abcdeffedcba98;
    key2R1      = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    key2R10     = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    expFips[0]  = fipsKey;
    expFips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    expFips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    expFips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    expFips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    expFips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    expFips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    expFips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    expFips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    expFips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    expFips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset with start held high: must stay idle.
    nRst = 1'b0;
    applyStimulus(1'b1, fipsKey, 1'b1);
    tick;
    tick;
    checkOutput("reset_hold", 1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
    nRst = 1'b1;
    applyStimulus(1'b0, fipsKey, 1'b1);
    tick;
    checkOutput("idle_after_reset", 1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
    tick;
    checkOutput("idle_stable", 1'b0, 1'b0, 1'b0, 4'd0, 128'h0);

    // FIPS-197 schedule with key_ready held high.
    $display("[TB] FIPS-197 schedule, no backpressure");
    applyStimulus(1'b1, fipsKey, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      tick;
      if (i == 0) applyStimulus(1'b0, fipsKey, 1'b1);
      checkOutput($sformatf("fips_r%0d", i), 1'b1, 1'b1, 1'b0, 4'(i), expFips[i]);
    end
    tick;
    checkOutput("fips_done", 1'b0, 1'b0, 1'b1, 4'd10, expFips[10]);
    tick;
    checkOutput("fips_done_clear", 1'b0, 1'b0, 1'b0, 4'd10, expFips[10]);

    // Backpressure at round 3, then a start with a different key at round 5.
    $display("[TB] backpressure and start-while-busy");
    applyStimulus(1'b1, fipsKey, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      tick;
      if (i == 0) applyStimulus(1'b0, fipsKey, 1'b1);
      checkOutput($sformatf("bp_r%0d", i), 1'b1, 1'b1, 1'b0, 4'(i), expFips[i]);
      if (i == 3) begin
        applyStimulus(1'b0, fipsKey, 1'b0);
        for (int s = 0; s < 5; s++) begin
          tick;
          checkOutput($sformatf("stall_%0d", s), 1'b1, 1'b1, 1'b0, 4'd3, expFips[3]);
        end
        applyStimulus(1'b0, fipsKey, 1'b1);
      end
      if (i == 5) applyStimulus(1'b1, otherKey, 1'b1);
      if (i == 6) applyStimulus(1'b0, otherKey, 1'b1);
    end
    tick;
    checkOutput("bp_done", 1'b0, 1'b0, 1'b1, 4'd10, expFips[10]);
    tick;
    checkOutput("bp_done_clear", 1'b0, 1'b0, 1'b0, 4'd10, expFips[10]);

    // Reset at round 7, then restart with a new key.
    $display("[TB] reset mid-schedule");
    applyStimulus(1'b1, fipsKey, 1'b1);
    for (int i = 0; i <= 7; i++) begin
      tick;
      if (i == 0) applyStimulus(1'b0, fipsKey, 1'b1);
      checkOutput($sformatf("mr_r%0d", i), 1'b1, 1'b1, 1'b0, 4'(i), expFips[i]);
    end
    nRst = 1'b0;
    tick;
    checkOutput("mid_reset", 1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
    nRst = 1'b1;
    applyStimulus(1'b1, key2, 1'b1);

    // Two back-to-back schedules of key2, the second started in the done cycle.
    for (int run = 0; run < 2; run++) begin
      tick;
      applyStimulus(1'b0, key2, 1'b1);
      checkOutput($sformatf("k2_run%0d_r0", run), 1'b1, 1'b1, 1'b0, 4'd0, key2);
      tick;
      checkOutput($sformatf("k2_run%0d_r1", run), 1'b1, 1'b1, 1'b0, 4'd1, key2R1);
      for (int i = 2; i <= 9; i++) begin
        tick;
        checkNum($sformatf("k2_run%0d_num%0d", run, i), 4'(i));
      end
      tick;
      checkOutput($sformatf("k2_run%0d_r10", run), 1'b1, 1'b1, 1'b0, 4'd10, key2R10);
      tick;
      checkOutput($sformatf("k2_run%0d_done", run), 1'b0, 1'b0, 1'b1, 4'd10, key2R10);
      if (run == 0) applyStimulus(1'b1, key2, 1'b1);
    end
    tick;
    checkOutput("k2_done_clear", 1'b0, 1'b0, 1'b0, 4'd10, key2R10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_key_gen.md
# round_key_gen

Sequential AES-128 key-schedule engine supplying the round keys consumed by the add_round_key stage that follows mix_columns in the cipher datapath. On a start pulse it captures the 128-bit cipher key and emits round keys 0 through 10 in order, one per valid/ready handshake. It expands one round key per cycle using one shared 4-byte S-box and an Rcon sequence. It is the per-round key source for the round controller.

## Interface
Parameters: none (AES-128 only; 10 rounds fixed).

- clk  input  1  system clock, rising-edge
- n_rst  input  1  reset, synchronous, active-low
- start  input  1  load key_in and begin a schedule; honoured only in IDLE
- key_in  input  128  cipher key; byte 0 = [127:120], column-major like the state bus
- key_ready  input  1  consumer accepts round_key this cycle
- key_valid  output  1  round_key/round_num valid
- round_key  output  128  current round key, same byte order as key_in
- round_num  output  4  index of round_key, 0..10
- busy  output  1  schedule in progress (state != IDLE)
- done  output  1  one-cycle pulse after round 10 is accepted

## Operation
- States: IDLE, EMIT.
- IDLE:
  - key_valid=0, busy=0.
  - On start=1: round_key<=key_in, round_num<=0, rcon<=8'h01, go to EMIT.
- EMIT:
  - key_valid=1, busy=1.
  - Handshake = key_valid & key_ready.
  - On handshake with round_num<10: round_key<=next_key(round_key, rcon), round_num+=1, rcon<=xtime(rcon). Stay in EMIT.
  - On handshake with round_num==10: go to IDLE, done<=1 for one cycle. round_key and round_num hold their last values.
  - No handshake: all registers hold. round_key and round_num stay stable while key_ready=0.
- next_key, with words w0..w3 where w0 = [127:96]:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - Computed combinationally in the same cycle.
- RotWord rotates bytes left: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
- SubWord applies the FIPS-197 S-box bytewise (4 instances).
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36. xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
- start while in EMIT is ignored; key_in is sampled only on the accepted start.
- Reset (n_rst=0 at a rising edge) has priority over everything, including mid-schedule and simultaneous start. It forces state=IDLE and all outputs to 0.

## Timing
- Reset values: key_valid=0, round_key=0, round_num=0, busy=0, done=0, rcon=8'h01.
- start sampled at edge N: key_valid=1 with round 0 (= key_in) from cycle N+1.
- Each handshake at edge M: the next round key is visible from cycle M+1. Zero bubbles, so throughput is one key per cycle.
- key_ready held high from N+1: round 10 is accepted at edge N+11, then done=1 and busy=0 in cycle N+12.
- A start in the done cycle (IDLE) is accepted; key_valid returns the cycle after.
- All outputs are registered; no combinational path from key_ready or start to any output.

## Test plan
- Reset: n_rst=0 for 2 cycles -> all outputs 0. Hold start=1 during reset -> still IDLE after release, key_valid=0.
- FIPS-197 vector, key_ready=1: key_in=2B7E151628AED2A6ABF7158809CF4F3C, pulse start -> required sequence:
  - round 0 = key_in
  - round 1 = A0FAFE1788542CB123A339392A6C7605
  - round 2 = F2C295F27A96B9435935807A7359F67F
  - round 10 = D014F9A8C9EE2589E13F0CC8B6630CA6
  - done pulses exactly once, at cycle N+12.
- Backpressure: same key, key_ready=0 for 5 cycles while round_num=3 -> round_key and round_num are unchanged each cycle; resume -> round 4 is correct.
- Start while busy: assert start with a different key_in at round 5 -> ignored; remaining keys match the original schedule.
- Reset mid-schedule: n_rst=0 at round 7 -> next cycle IDLE with outputs 0. A new start then produces round 0 = new key_in and rcon restarts at 01.
- Back-to-back: start in the done cycle with key_in=000102030405060708090A0B0C0D0E0F -> round 10 = 13111D7FE3944A17F307A78B4D2B30C5.
